// File: rtl/dcache_pkg.sv
// Shared definitions for the MEM-stage data cache: access codes, FSM states
// and the default geometry with its derived address-field widths.
package dcache_pkg;

   localparam int DEF_LINES = 16;
   localparam int DEF_WORDS = 4;

   // Address fields at the default geometry: [OFF_W+1:2] word, then index, then tag.
   localparam int IDX_W  = $clog2(DEF_LINES);
   localparam int OFF_W  = $clog2(DEF_WORDS);
   localparam int TAG_W  = 32 - IDX_W - OFF_W - 2;
   localparam int LINE_W = 32 * DEF_WORDS;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_LOAD  = 2'b01;
   localparam logic [1:0] MEM_STORE = 2'b10;

   typedef enum logic [1:0] {
      ST_COMPARE   = 2'd0,
      ST_WRITEBACK = 2'd1,
      ST_ALLOCATE  = 2'd2
   } state_e;

endpackage

// File: rtl/dcache_if.sv
// Pipeline-side and backing-memory-side signals of the data cache.
// Backing memory handshake: m_req_o rises to start a line transfer and holds
// m_we_o/m_addr_o/m_wdata_o stable until a one-cycle m_ack_i pulse; the
// transfer completes on the clock edge where m_ack_i is high, and m_ack_i
// is ignored while m_req_o is low. Only one transfer is ever outstanding.
interface dcache_if #(parameter int WORDS = 4);
   import dcache_pkg::*;

   logic [1:0]          mem_ctrl_i;
   logic [31:0]         addr_i;
   logic [31:0]         wdata_i;
   logic [31:0]         rdata_o;
   logic                stall_o;
   logic                m_req_o;
   logic                m_we_o;
   logic [31:0]         m_addr_o;
   logic [32*WORDS-1:0] m_wdata_o;
   logic                m_ack_i;
   logic [32*WORDS-1:0] m_rdata_i;
   state_e              dbg_state;

   modport slave (
      input  mem_ctrl_i, addr_i, wdata_i, m_ack_i, m_rdata_i,
      output rdata_o, stall_o, m_req_o, m_we_o, m_addr_o, m_wdata_o, dbg_state
   );

   modport master (
      output mem_ctrl_i, addr_i, wdata_i, m_ack_i, m_rdata_i,
      input  rdata_o, stall_o, m_req_o, m_we_o, m_addr_o, m_wdata_o, dbg_state
   );

endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for a direct-mapped cache. One combinational
// read port; synchronous word write, line fill and dirty-clear at one index.
module dcache_array
   import dcache_pkg::*;
#(
   parameter  int LINES  = DEF_LINES,
   parameter  int WORDS  = DEF_WORDS,
   localparam int A_IDX  = $clog2(LINES),
   localparam int A_OFF  = $clog2(WORDS),
   localparam int A_TAG  = 32 - A_IDX - A_OFF - 2,
   localparam int A_LINE = 32 * WORDS
)
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [A_IDX-1:0]  idx_i,
   output logic              rd_valid_o,
   output logic              rd_dirty_o,
   output logic [A_TAG-1:0]  rd_tag_o,
   output logic [A_LINE-1:0] rd_line_o,
   input  logic              word_we_i,
   input  logic [A_OFF-1:0]  word_off_i,
   input  logic [31:0]       word_i,
   input  logic              fill_we_i,
   input  logic [A_TAG-1:0]  fill_tag_i,
   input  logic [A_LINE-1:0] fill_line_i,
   input  logic              clean_i
);

   logic [LINES-1:0]  valid_q, valid_d;
   logic [LINES-1:0]  dirty_q, dirty_d;
   logic [A_TAG-1:0]  tag_q  [LINES];
   logic [A_TAG-1:0]  tag_d  [LINES];
   logic [A_LINE-1:0] data_q [LINES];
   logic [A_LINE-1:0] data_d [LINES];

   assign rd_valid_o = valid_q[idx_i];
   assign rd_dirty_o = dirty_q[idx_i];
   assign rd_tag_o   = tag_q[idx_i];
   assign rd_line_o  = data_q[idx_i];

   // Next contents: a fill replaces the whole line clean; a word store marks it dirty.
   always_comb begin
      valid_d = valid_q;
      dirty_d = dirty_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (fill_we_i) begin
         valid_d[idx_i] = 1'b1;
         dirty_d[idx_i] = 1'b0;
         tag_d[idx_i]   = fill_tag_i;
         data_d[idx_i]  = fill_line_i;
      end
      if (word_we_i) begin
         dirty_d[idx_i] = 1'b1;
         data_d[idx_i][{word_off_i, 5'd0} +: 32] = word_i;
      end
      if (clean_i) begin
         dirty_d[idx_i] = 1'b0;
      end
   end

   // Line state bits: reset invalidates everything and drops dirty data.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         valid_q <= valid_d;
         dirty_q <= dirty_d;
      end
   end

   // Tag and data payload need no reset; valid gates their use.
   always_ff @(posedge clk_i) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller for the MEM
// stage. Misses stall the pipeline while a dirty victim is written back and
// the requested line is fetched; the access then completes as a hit.
module dcache_ctrl
   import dcache_pkg::*;
#(
   parameter int LINES = DEF_LINES,
   parameter int WORDS = DEF_WORDS
)
(
   input  logic     clk_i,
   input  logic     rst_i,
   dcache_if.slave  bus
);

   localparam int C_IDX  = $clog2(LINES);
   localparam int C_OFF  = $clog2(WORDS);
   localparam int C_TAG  = 32 - C_IDX - C_OFF - 2;
   localparam int C_LINE = 32 * WORDS;

   state_e             state_q, state_d;
   logic [C_OFF-1:0]   off;
   logic [C_IDX-1:0]   idx;
   logic [C_TAG-1:0]   tag;
   logic               is_load, is_store, is_access, hit;
   logic               rd_valid, rd_dirty;
   logic [C_TAG-1:0]   rd_tag;
   logic [C_LINE-1:0]  rd_line;
   logic               word_we, fill_we, clean, stall_c;

   assign off       = bus.addr_i[2 +: C_OFF];
   assign idx       = bus.addr_i[2 + C_OFF +: C_IDX];
   assign tag       = bus.addr_i[31 -: C_TAG];
   assign is_load   = (bus.mem_ctrl_i == MEM_LOAD);
   assign is_store  = (bus.mem_ctrl_i == MEM_STORE);
   assign is_access = is_load || is_store;
   assign hit       = rd_valid && (rd_tag == tag) && is_access;
   assign bus.dbg_state = state_q;

   dcache_array #(.LINES(LINES), .WORDS(WORDS)) u_array (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .idx_i       (idx),
      .rd_valid_o  (rd_valid),
      .rd_dirty_o  (rd_dirty),
      .rd_tag_o    (rd_tag),
      .rd_line_o   (rd_line),
      .word_we_i   (word_we),
      .word_off_i  (off),
      .word_i      (bus.wdata_i),
      .fill_we_i   (fill_we),
      .fill_tag_i  (tag),
      .fill_line_i (bus.m_rdata_i),
      .clean_i     (clean)
   );

   // State register; reset aborts any transfer in flight.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_COMPARE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: a miss evicts (if dirty) then fetches; each step waits for ack.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_COMPARE: begin
            if (is_access && !hit) begin
               state_d = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
            end
         end
         ST_WRITEBACK: if (bus.m_ack_i) state_d = ST_ALLOCATE;
         ST_ALLOCATE:  if (bus.m_ack_i) state_d = ST_COMPARE;
         default:      state_d = ST_COMPARE;
      endcase
   end

   // Outputs: hit data/stores in COMPARE, held request fields while transferring.
   always_comb begin
      bus.rdata_o   = '0;
      bus.m_req_o   = 1'b0;
      bus.m_we_o    = 1'b0;
      bus.m_addr_o  = '0;
      bus.m_wdata_o = '0;
      word_we       = 1'b0;
      fill_we       = 1'b0;
      clean         = 1'b0;
      stall_c       = 1'b0;
      case (state_q)
         ST_COMPARE: begin
            stall_c = is_access && !hit;
            word_we = is_store && hit;
            if (is_load && hit) begin
               bus.rdata_o = rd_line[{off, 5'd0} +: 32];
            end
         end
         ST_WRITEBACK: begin
            stall_c       = 1'b1;
            bus.m_req_o   = 1'b1;
            bus.m_we_o    = 1'b1;
            bus.m_addr_o  = {rd_tag, idx, {(C_OFF + 2){1'b0}}};
            bus.m_wdata_o = rd_line;
            clean         = bus.m_ack_i;
         end
         ST_ALLOCATE: begin
            stall_c      = 1'b1;
            bus.m_req_o  = 1'b1;
            bus.m_addr_o = {tag, idx, {(C_OFF + 2){1'b0}}};
            fill_we      = bus.m_ack_i;
         end
         default: ;
      endcase
      // While reset is held the pipeline must not see a stall from a cold miss.
      bus.stall_o = stall_c & ~rst_i;
   end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: directed scenarios plus random
// accesses against a cache/backing-memory reference model.
module tb_dcache_ctrl;
   import dcache_pkg::*;

   logic clk = 1'b0;
   logic rst;

   dcache_if #(.WORDS(4)) bus ();

   dcache_ctrl #(.LINES(16), .WORDS(4)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   // clock
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // reference model: backing memory by line address, cache lines by index
   logic [127:0] mem_lines [logic [31:0]];
   logic         m_valid [16];
   logic         m_dirty [16];
   logic [23:0]  m_tag   [16];
   logic [127:0] m_line  [16];

   // observations from the driver
   int           o_stall;
   bit           o_wb, o_fill, o_unstable, o_timeout, o_req_idle;
   logic [31:0]  o_wb_addr, o_fill_addr, o_rdata;
   logic [127:0] o_wb_data;

   // expectations from the model
   bit           e_miss, e_wb;
   logic [31:0]  e_wb_addr, e_fill_addr, e_rdata;
   logic [127:0] e_wb_data;

   function automatic logic [127:0] mem_read(input logic [31:0] a);
      logic [127:0] l;
      if (mem_lines.exists(a)) return mem_lines[a];
      for (int w = 0; w < 4; w++) l[w*32 +: 32] = (a + 32'(w * 4)) ^ 32'hC0DE_0000;
      return l;
   endfunction

   function automatic int exp_stall(input int lat);
      if (!e_miss) return 0;
      return 1 + (e_wb ? lat + 1 : 0) + lat + 1;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 16; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
      end
   endtask

   task automatic model_access(input logic [1:0] ctrl, input logic [31:0] addr, input logic [31:0] wd);
      int idx, w;
      logic [23:0] tg;
      logic [31:0] la;
      idx = int'((addr >> 4) % 16);
      w   = int'((addr >> 2) % 4);
      tg  = 24'(addr >> 8);
      la  = addr & 32'hFFFF_FFF0;
      e_miss = 0; e_wb = 0; e_wb_addr = '0; e_wb_data = '0; e_fill_addr = '0; e_rdata = '0;
      if (ctrl != MEM_LOAD && ctrl != MEM_STORE) return;
      if (!(m_valid[idx] && m_tag[idx] == tg)) begin
         e_miss = 1;
         if (m_valid[idx] && m_dirty[idx]) begin
            e_wb      = 1;
            e_wb_addr = 32'(m_tag[idx]) * 256 + 32'(idx * 16);
            e_wb_data = m_line[idx];
            mem_lines[e_wb_addr] = m_line[idx];
         end
         e_fill_addr  = la;
         m_line[idx]  = mem_read(la);
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
         m_tag[idx]   = tg;
      end
      if (ctrl == MEM_LOAD) begin
         e_rdata = m_line[idx][w*32 +: 32];
      end else begin
         m_line[idx][w*32 +: 32] = wd;
         m_dirty[idx] = 1'b1;
      end
   endtask

   // driver: present one access, play backing memory with 'lat' wait cycles per transfer
   task automatic run_access(input logic [1:0] ctrl, input logic [31:0] addr,
                             input logic [31:0] wd, input int lat);
      int req_cnt;
      bit done;
      req_cnt = 0; done = 0;
      o_stall = 0; o_wb = 0; o_fill = 0; o_unstable = 0; o_timeout = 0; o_req_idle = 0;
      o_wb_addr = '0; o_wb_data = '0; o_fill_addr = '0; o_rdata = '0;
      bus.mem_ctrl_i = ctrl;
      bus.addr_i     = addr;
      bus.wdata_i    = wd;
      for (int cyc = 0; cyc < 64 && !done; cyc++) begin
         @(negedge clk);
         bus.m_ack_i = 1'b0;
         if (!bus.stall_o) begin
            o_rdata    = bus.rdata_o;
            o_req_idle = bus.m_req_o;
            done       = 1;
         end else begin
            o_stall++;
            if (bus.m_req_o) begin
               if (bus.m_we_o) begin
                  if (req_cnt == 0) begin
                     o_wb = 1; o_wb_addr = bus.m_addr_o; o_wb_data = bus.m_wdata_o;
                  end else if (bus.m_addr_o !== o_wb_addr || bus.m_wdata_o !== o_wb_data) begin
                     o_unstable = 1;
                  end
               end else begin
                  if (req_cnt == 0) begin
                     o_fill = 1; o_fill_addr = bus.m_addr_o;
                  end else if (bus.m_addr_o !== o_fill_addr) begin
                     o_unstable = 1;
                  end
               end
               req_cnt++;
               if (req_cnt == lat + 1) begin
                  bus.m_ack_i   = 1'b1;
                  bus.m_rdata_i = mem_read(bus.m_addr_o);
                  req_cnt       = 0;
               end
            end
         end
      end
      o_timeout = !done;
      @(posedge clk);
      #1;
      bus.mem_ctrl_i = MEM_NONE;
      bus.m_ack_i    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.mem_ctrl_i = MEM_LOAD; bus.addr_i = 32'h104; bus.wdata_i = '0;
      bus.m_ack_i = 1'b0; bus.m_rdata_i = '0;
      repeat (2) @(negedge clk);
      n_vec++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", bus.stall_o); end
      n_vec++; if (bus.m_req_o !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", bus.m_req_o); end
      n_vec++; if (bus.m_we_o !== 1'b0) begin n_err++; $display("FAIL reset_we got %b want 0", bus.m_we_o); end
      n_vec++; if (bus.m_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_maddr got %h want 0", bus.m_addr_o); end
      n_vec++; if (bus.m_wdata_o !== 128'h0) begin n_err++; $display("FAIL reset_mwdata got %h want 0", bus.m_wdata_o); end
      n_vec++; if (bus.rdata_o !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", bus.rdata_o); end
      n_vec++; if (bus.dbg_state !== ST_COMPARE) begin n_err++; $display("FAIL reset_state got %0d want COMPARE", bus.dbg_state); end
      bus.mem_ctrl_i = MEM_NONE;
      rst = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
   endtask

   task automatic check_proto(input string name);
      n_vec++;
      if (o_unstable || o_timeout || o_req_idle) begin
         n_err++;
         $display("FAIL %s_proto unstable=%0b timeout=%0b req_when_idle=%0b want all 0",
                  name, o_unstable, o_timeout, o_req_idle);
      end
   endtask

   task automatic test_cold_load();
      mem_lines[32'h100] = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'h1111_1111};
      model_access(MEM_LOAD, 32'h104, '0);
      run_access(MEM_LOAD, 32'h104, '0, 3);
      n_vec++; if (o_stall != 5) begin n_err++; $display("FAIL cold_stall got %0d want 5", o_stall); end
      n_vec++; if (o_wb !== 1'b0) begin n_err++; $display("FAIL cold_no_wb got %b want 0", o_wb); end
      n_vec++; if (o_fill_addr !== 32'h100) begin n_err++; $display("FAIL cold_fill_addr got %h want 00000100", o_fill_addr); end
      n_vec++; if (o_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL cold_rdata got %h want deadbeef", o_rdata); end
      check_proto("cold");
   endtask

   task automatic test_store_load_hit();
      model_access(MEM_STORE, 32'h104, 32'h1234_5678);
      run_access(MEM_STORE, 32'h104, 32'h1234_5678, 3);
      n_vec++; if (o_stall != 0) begin n_err++; $display("FAIL st_hit_stall got %0d want 0", o_stall); end
      check_proto("st_hit");
      model_access(MEM_LOAD, 32'h104, '0);
      run_access(MEM_LOAD, 32'h104, '0, 3);
      n_vec++; if (o_stall != 0) begin n_err++; $display("FAIL ld_hit_stall got %0d want 0", o_stall); end
      n_vec++; if (o_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL ld_hit_rdata got %h want 12345678", o_rdata); end
      check_proto("ld_hit");
   endtask

   task automatic test_dirty_evict();
      model_access(MEM_LOAD, 32'h204, '0);
      run_access(MEM_LOAD, 32'h204, '0, 2);
      n_vec++; if (o_wb !== 1'b1) begin n_err++; $display("FAIL dirty_wb_seen got %b want 1", o_wb); end
      n_vec++; if (o_wb_addr !== 32'h100) begin n_err++; $display("FAIL dirty_wb_addr got %h want 00000100", o_wb_addr); end
      n_vec++; if (o_wb_data[63:32] !== 32'h1234_5678) begin n_err++; $display("FAIL dirty_wb_word1 got %h want 12345678", o_wb_data[63:32]); end
      n_vec++; if (o_wb_data !== e_wb_data) begin n_err++; $display("FAIL dirty_wb_line got %h want %h", o_wb_data, e_wb_data); end
      n_vec++; if (o_fill_addr !== 32'h200) begin n_err++; $display("FAIL dirty_fill_addr got %h want 00000200", o_fill_addr); end
      n_vec++; if (o_stall != 7) begin n_err++; $display("FAIL dirty_stall got %0d want 7", o_stall); end
      n_vec++; if (o_rdata !== e_rdata) begin n_err++; $display("FAIL dirty_rdata got %h want %h", o_rdata, e_rdata); end
      check_proto("dirty");
   endtask

   task automatic test_clean_evict();
      model_access(MEM_LOAD, 32'h304, '0);
      run_access(MEM_LOAD, 32'h304, '0, 1);
      n_vec++; if (o_wb !== 1'b0) begin n_err++; $display("FAIL clean_no_wb got %b want 0", o_wb); end
      n_vec++; if (o_fill_addr !== 32'h300) begin n_err++; $display("FAIL clean_fill_addr got %h want 00000300", o_fill_addr); end
      n_vec++; if (o_stall != 3) begin n_err++; $display("FAIL clean_stall got %0d want 3", o_stall); end
      n_vec++; if (o_rdata !== e_rdata) begin n_err++; $display("FAIL clean_rdata got %h want %h", o_rdata, e_rdata); end
      check_proto("clean");
   endtask

   task automatic test_idle_codes();
      logic [1:0]  ctrl;
      logic [31:0] a;
      for (int i = 0; i < 6; i++) begin
         ctrl = (i % 2 == 0) ? 2'b00 : 2'b11;
         a    = (i < 2) ? 32'h104 : $urandom;
         model_access(ctrl, a, $urandom);
         run_access(ctrl, a, $urandom, 1);
         n_vec++; if (o_stall != 0) begin n_err++; $display("FAIL idle_stall[%0d] got %0d want 0", i, o_stall); end
         n_vec++; if (o_rdata !== 32'h0) begin n_err++; $display("FAIL idle_rdata[%0d] got %h want 0", i, o_rdata); end
         check_proto("idle");
      end
      // the cached line must be untouched
      model_access(MEM_LOAD, 32'h304, '0);
      run_access(MEM_LOAD, 32'h304, '0, 1);
      n_vec++; if (o_stall != 0) begin n_err++; $display("FAIL idle_keep_stall got %0d want 0", o_stall); end
      n_vec++; if (o_rdata !== e_rdata) begin n_err++; $display("FAIL idle_keep_rdata got %h want %h", o_rdata, e_rdata); end
   endtask

   task automatic test_reset_mid_fill();
      bit found;
      found = 0;
      bus.mem_ctrl_i = MEM_LOAD;
      bus.addr_i     = 32'h404;
      bus.m_ack_i    = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
         @(negedge clk);
         if (bus.m_req_o === 1'b1 && bus.m_we_o === 1'b0) found = 1;
      end
      n_vec++; if (!found) begin n_err++; $display("FAIL rmf_alloc_req got 0 want 1"); end
      rst = 1'b1;
      #1;
      n_vec++; if (bus.m_req_o !== 1'b0) begin n_err++; $display("FAIL rmf_req got %b want 0", bus.m_req_o); end
      n_vec++; if (bus.stall_o !== 1'b0) begin n_err++; $display("FAIL rmf_stall got %b want 0", bus.stall_o); end
      n_vec++; if (bus.dbg_state !== ST_COMPARE) begin n_err++; $display("FAIL rmf_state got %0d want COMPARE", bus.dbg_state); end
      @(negedge clk);
      rst = 1'b0;
      bus.mem_ctrl_i = MEM_NONE;
      model_clear();
      @(posedge clk);
      #1;
      model_access(MEM_LOAD, 32'h304, '0);
      run_access(MEM_LOAD, 32'h304, '0, 2);
      n_vec++; if (o_stall != 4) begin n_err++; $display("FAIL rmf_reload_stall got %0d want 4", o_stall); end
      n_vec++; if (o_fill_addr !== 32'h300) begin n_err++; $display("FAIL rmf_reload_fill got %h want 00000300", o_fill_addr); end
      n_vec++; if (o_rdata !== e_rdata) begin n_err++; $display("FAIL rmf_reload_rdata got %h want %h", o_rdata, e_rdata); end
   endtask

   task automatic test_random();
      logic [1:0]  ctrl;
      logic [31:0] a, wd;
      int lat, es;
      for (int i = 0; i < 150; i++) begin
         ctrl = 2'($urandom_range(0, 3));
         a    = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         wd   = $urandom;
         lat  = $urandom_range(0, 3);
         model_access(ctrl, a, wd);
         es = exp_stall(lat);
         run_access(ctrl, a, wd, lat);
         n_vec++; if (o_stall != es) begin n_err++; $display("FAIL rand_stall[%0d] addr=%h got %0d want %0d", i, a, o_stall, es); end
         n_vec++; if (o_rdata !== e_rdata) begin n_err++; $display("FAIL rand_rdata[%0d] addr=%h got %h want %h", i, a, o_rdata, e_rdata); end
         n_vec++; if (o_wb !== e_wb) begin n_err++; $display("FAIL rand_wb_seen[%0d] got %b want %b", i, o_wb, e_wb); end
         if (e_wb) begin
            n_vec++; if (o_wb_addr !== e_wb_addr) begin n_err++; $display("FAIL rand_wb_addr[%0d] got %h want %h", i, o_wb_addr, e_wb_addr); end
            n_vec++; if (o_wb_data !== e_wb_data) begin n_err++; $display("FAIL rand_wb_data[%0d] got %h want %h", i, o_wb_data, e_wb_data); end
         end
         if (e_miss) begin
            n_vec++; if (o_fill_addr !== e_fill_addr) begin n_err++; $display("FAIL rand_fill_addr[%0d] got %h want %h", i, o_fill_addr, e_fill_addr); end
         end
         check_proto("rand");
      end
   endtask

   initial begin
      test_reset();
      test_cold_load();
      test_store_load_hit();
      test_dirty_evict();
      test_clean_evict();
      test_idle_codes();
      test_reset_mid_fill();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
